// File: rtl/divider.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU; one quotient bit per cycle.
// Divide-by-zero and signed overflow complete in one cycle without entering CALC.
module divider #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   typedef enum logic [1:0] {StIdle, StCalc, StFixup} state_e;

   state_e           state_q, state_d;
   logic [5:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] div_q, div_d;
   logic             sel_rem_q, sel_rem_d;
   logic             q_neg_q, q_neg_d;
   logic             r_neg_q, r_neg_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] result_q, result_d;

   logic             is_signed;
   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic             div_zero, overflow;
   logic [WIDTH-1:0] fast_res;
   logic [WIDTH:0]   shifted, trial;
   logic [WIDTH-1:0] q_fix, r_fix;

   always_comb begin
      is_signed = ~op[0];
      a_neg     = is_signed & a[WIDTH-1];
      b_neg     = is_signed & b[WIDTH-1];
      a_mag     = a_neg ? -a : a;
      b_mag     = b_neg ? -b : b;
      div_zero  = (b == '0);
      overflow  = is_signed && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
      // Overflow quotient is the dividend itself (most negative value).
      if (div_zero) fast_res = op[1] ? a : '1;
      else          fast_res = op[1] ? '0 : a;

      // Trial subtract is 33 bits wide; bit WIDTH set means the divisor did not fit.
      shifted = {rem_q, quo_q[WIDTH-1]};
      trial   = shifted - {1'b0, div_q};

      q_fix = q_neg_q ? -quo_q : quo_q;
      r_fix = r_neg_q ? -rem_q : rem_q;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      div_d     = div_q;
      sel_rem_d = sel_rem_q;
      q_neg_d   = q_neg_q;
      r_neg_d   = r_neg_q;
      done_d    = 1'b0;
      result_d  = result_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               sel_rem_d = op[1];
               q_neg_d   = a_neg ^ b_neg;
               r_neg_d   = a_neg;
               if (div_zero || overflow) begin
                  done_d   = 1'b1;
                  result_d = fast_res;
               end else begin
                  state_d = StCalc;
                  cnt_d   = 6'(WIDTH - 1);
                  rem_d   = '0;
                  quo_d   = a_mag;
                  div_d   = b_mag;
               end
            end
         end
         StCalc: begin
            if (!trial[WIDTH]) begin
               rem_d = trial[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
               rem_d = shifted[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            if (cnt_q == 6'd0) state_d = StFixup;
            else               cnt_d   = cnt_q - 6'd1;
         end
         StFixup: begin
            state_d  = StIdle;
            done_d   = 1'b1;
            result_d = sel_rem_q ? r_fix : q_fix;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         div_q     <= '0;
         sel_rem_q <= 1'b0;
         q_neg_q   <= 1'b0;
         r_neg_q   <= 1'b0;
         done_q    <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         div_q     <= div_d;
         sel_rem_q <= sel_rem_d;
         q_neg_q   <= q_neg_d;
         r_neg_q   <= r_neg_d;
         done_q    <= done_d;
         result_q  <= result_d;
      end
   end

   assign busy   = (state_q != StIdle);
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_divider.sv
// Directed bench for divider: arithmetic, fast paths, back-to-back issue and mid-run reset.
module tb_divider;

   localparam logic [1:0] OpDiv  = 2'b00;
   localparam logic [1:0] OpDivu = 2'b01;
   localparam logic [1:0] OpRem  = 2'b10;
   localparam logic [1:0] OpRemu = 2'b11;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a, b;
   logic        busy, done;
   logic [31:0] result;

   int checks   = 0;
   int failures = 0;

   divider #(.WIDTH(32)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   // Issues one request, scrambles operands after acceptance, and waits for done.
   // nidx is the index of the negedge after acceptance at which done was seen.
   task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] res, output int nidx, output int busy_cnt,
                         output logic done_after);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(negedge clk);
      start = 1'b0; a = ~x; b = y ^ 32'h5a5a_a5a5;
      nidx = 1; busy_cnt = 0;
      while (done !== 1'b1 && nidx < 40) begin
         if (busy === 1'b1) busy_cnt++;
         @(negedge clk);
         nidx++;
      end
      if (busy === 1'b1) busy_cnt++;
      res = result;
      @(negedge clk);
      done_after = done;
   endtask

   task automatic test_reset;
      rst = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
         failures++;
         $display("FAIL reset_state: busy=%b done=%b result=%h, required 0 0 00000000",
                  busy, done, result);
      end
      rst = 1'b1;
   endtask

   task automatic test_unsigned;
      logic [1:0]  ops [3];
      logic [31:0] xs [3], ys [3], exp [3];
      logic [31:0] res; int nidx, bc; logic da;
      ops = '{OpDivu, OpRemu, OpDivu};
      xs  = '{32'd100, 32'd100, 32'd1000};
      ys  = '{32'd7, 32'd7, 32'd1};
      exp = '{32'd14, 32'd2, 32'd1000};
      for (int i = 0; i < 3; i++) begin
         run_op(ops[i], xs[i], ys[i], res, nidx, bc, da);
         checks++;
         if (res !== exp[i]) begin
            failures++;
            $display("FAIL unsigned_result[%0d]: got %h, required %h", i, res, exp[i]);
         end
         checks++;
         if (nidx !== 34 || bc !== 33 || da !== 1'b0) begin
            failures++;
            $display("FAIL unsigned_timing[%0d]: done at negedge %0d busy %0d cycles pulse_after=%b, required 34 33 0",
                     i, nidx, bc, da);
         end
      end
   endtask

   task automatic test_signed;
      logic [1:0]  ops [5];
      logic [31:0] xs [5], ys [5], exp [5];
      logic [31:0] res; int nidx, bc; logic da;
      ops = '{OpDiv, OpRem, OpRem, OpDiv, OpRem};
      xs  = '{-32'sd7, -32'sd7, 32'd7, 32'd7, -32'sd7};
      ys  = '{32'd2, 32'd2, -32'sd2, -32'sd2, -32'sd2};
      exp = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
      for (int i = 0; i < 5; i++) begin
         run_op(ops[i], xs[i], ys[i], res, nidx, bc, da);
         checks++;
         if (res !== exp[i] || nidx !== 34) begin
            failures++;
            $display("FAIL signed[%0d]: got %h at negedge %0d, required %h at 34",
                     i, res, nidx, exp[i]);
         end
      end
   endtask

   task automatic test_fast_path;
      logic [1:0]  ops [6];
      logic [31:0] xs [6], ys [6], exp [6];
      logic [31:0] res; int nidx, bc; logic da;
      ops = '{OpDivu, OpRem, OpDiv, OpRem, OpRemu, OpDiv};
      xs  = '{32'd5, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'd5, 32'd3};
      ys  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
      exp = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'd5, 32'hFFFF_FFFF};
      for (int i = 0; i < 6; i++) begin
         run_op(ops[i], xs[i], ys[i], res, nidx, bc, da);
         checks++;
         if (res !== exp[i]) begin
            failures++;
            $display("FAIL fast_result[%0d]: got %h, required %h", i, res, exp[i]);
         end
         checks++;
         if (nidx !== 1 || bc !== 0 || da !== 1'b0) begin
            failures++;
            $display("FAIL fast_timing[%0d]: done at negedge %0d busy %0d cycles pulse_after=%b, required 1 0 0",
                     i, nidx, bc, da);
         end
      end
   endtask

   task automatic test_back_to_back;
      int nidx;
      @(negedge clk);
      start = 1'b1; op = OpDivu; a = 32'hFFFF_FFFF; b = 32'd1;
      nidx = 0;
      do begin
         @(negedge clk);
         nidx++;
         if (done !== 1'b1) begin
            a = $urandom; b = $urandom;
         end
      end while (done !== 1'b1 && nidx < 40);
      checks++;
      if (nidx !== 34 || result !== 32'hFFFF_FFFF || busy !== 1'b0) begin
         failures++;
         $display("FAIL b2b_first: done at negedge %0d result %h busy %b, required 34 ffffffff 0",
                  nidx, result, busy);
      end
      a = 32'd1; b = 32'hFFFF_FFFF;
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         failures++;
         $display("FAIL b2b_accept: busy=%b done=%b, required 1 0", busy, done);
      end
      start = 1'b0;
      nidx = 1;
      while (done !== 1'b1 && nidx < 40) begin
         @(negedge clk);
         nidx++;
      end
      checks++;
      if (nidx !== 34 || result !== 32'h0) begin
         failures++;
         $display("FAIL b2b_second: done at negedge %0d result %h, required 34 00000000",
                  nidx, result);
      end
   endtask

   task automatic test_reset_mid;
      logic [31:0] res; int nidx, bc; logic da;
      run_op(OpDivu, 32'd100, 32'd7, res, nidx, bc, da);
      checks++;
      if (res !== 32'd14) begin
         failures++;
         $display("FAIL pre_reset_result: got %h, required 0000000e", res);
      end
      @(negedge clk);
      start = 1'b1; op = OpDivu; a = 32'd1000; b = 32'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || result !== 32'h0 || done !== 1'b0) begin
         failures++;
         $display("FAIL reset_abort: busy=%b result=%h done=%b, required 0 00000000 0",
                  busy, result, done);
      end
      @(negedge clk);
      rst = 1'b1;
      start = 1'b1; op = OpDivu; a = 32'd9; b = 32'd3;
      @(negedge clk);
      start = 1'b0;
      nidx = 1;
      while (done !== 1'b1 && nidx < 40) begin
         @(negedge clk);
         nidx++;
      end
      checks++;
      if (nidx !== 34 || result !== 32'd3) begin
         failures++;
         $display("FAIL post_reset: done at negedge %0d result %h, required 34 00000003",
                  nidx, result);
      end
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_fast_path();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/divider.md
# divider

Iterative 32-bit integer divide unit for the RV32M DIV, DIVU, REM and REMU instructions. It sits beside the single-cycle ALU in the execute stage. The pipeline stalls on `busy` while the unit computes one quotient bit per cycle with a restoring algorithm, then releases the stall on a one-cycle `done` pulse. It implements RISC-V divide-by-zero and signed-overflow results exactly, without trapping.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width. Only 32 is supported by the rv32i datapath.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous, active-low; asserting it forces reset state immediately.
- `start`  in  1: request strobe; sampled only while `busy` is low.
- `op`  in  2: function select equal to funct3[1:0]. 00 = DIV, 01 = DIVU, 10 = REM, 11 = REMU.
- `a`  in  32 (`rv32i_word`): dividend; sampled on the accepting edge.
- `b`  in  32 (`rv32i_word`): divisor; sampled on the accepting edge.
- `busy`  out  1: high from the edge after acceptance through the last compute cycle.
- `done`  out  1: one-cycle pulse; `result` is valid in that cycle.
- `result`  out  32 (`rv32i_word`): quotient or remainder; held until the next `done`.

## Operation
- States: IDLE, CALC, FIXUP.
  - IDLE: `busy` = 0.
  - CALC and FIXUP: `busy` = 1.
- Acceptance occurs on a rising edge with `start` = 1 and state IDLE. Registers `op`, `a` and `b`. `start` in any other state is ignored; it is not queued.
- Operand preparation on acceptance:
  - Signed ops (DIV, REM): the unit registers the magnitudes |a| and |b|.
  - It also registers `q_neg` = a[31]^b[31] and `r_neg` = a[31].
  - Unsigned ops: `q_neg` = `r_neg` = 0.
- Fast paths, decided at acceptance:
  - Go straight to IDLE with `done` = 1 on the next cycle; CALC and FIXUP are skipped.
  - b == 0: DIV/DIVU give result 0xFFFFFFFF; REM/REMU give result `a`.
  - DIV/REM with a == 0x80000000 and b == 0xFFFFFFFF: DIV gives 0x80000000; REM gives 0.
- CALC runs 32 iterations, one per cycle, with a 6-bit counter counting 31 down to 0. Each iteration:
  - Shift {rem, quo} left one bit, bringing in the dividend MSB.
  - Trial subtract on 33 bits: rem − divisor.
  - If the result is non-negative, keep the difference and set the quotient LSB to 1; otherwise restore and set the LSB to 0.
  - After counter value 0, go to FIXUP.
- FIXUP:
  - Quotient is negated (two's complement) if `q_neg`.
  - Remainder is negated if `r_neg`.
  - `result` = quotient for op[1] = 0, remainder for op[1] = 1.
  - `result` and `done` are registered; state returns to IDLE.
- Invariant: for the non-fast path, |remainder| < |b|, and the remainder has the dividend's sign or is zero.
- `result` is never modified except on the edge that raises `done`.

## Timing
- Accepting edge is k.
- Normal path:
  - CALC occupies edges k+1 through k+32.
  - FIXUP is evaluated on edge k+33.
  - `done` = 1 from edge k+33 to k+34 (latency 33 cycles).
  - `busy` = 1 from edge k to edge k+33.
- Fast path: `done` = 1 from edge k to k+1; `busy` stays 0.
- Back-to-back: in the `done` cycle the state is IDLE and `busy` = 0, so `start` in that cycle is accepted. The throughput is one result per 33 cycles.
- Reset state, asynchronous on `rst` low: state IDLE, counter 0, `busy` = 0, `done` = 0, `result` = 0, and internal rem/quo/divisor = 0.
  - Reset mid-CALC aborts with no `done`.
  - The first edge after `rst` is released may accept `start`.
- Operand inputs may change freely after the accepting edge without affecting the result.

## Test plan
- DIVU 100 / 7, `start` pulsed once -> `busy` for 33 cycles, then `done` for one cycle with `result` = 14. REMU, same operands -> 2.
- DIV −7 / 2 -> −3 (0xFFFFFFFD); REM −7 / 2 -> −1 (0xFFFFFFFF); REM 7 / −2 -> 1.
- DIVU 5 / 0 -> `done` one cycle after acceptance, `result` 0xFFFFFFFF, `busy` never high. REM 0x80000000 / 0 -> 0x80000000.
- DIV 0x80000000 / 0xFFFFFFFF -> fast path, `result` 0x80000000; REM, same operands -> 0.
- `start` held high continuously with DIVU 0xFFFFFFFF / 1 then DIVU 1 / 0xFFFFFFFF -> the second request is accepted exactly in the first request's `done` cycle; results 0xFFFFFFFF then 0. Toggling `a` and `b` during CALC has no effect.
- `rst` low for one cycle at iteration 10 of a DIVU -> immediately `busy` = 0, `result` = 0, no `done`. A new DIVU 9 / 3 after release -> 3.
